seq_detect_param: RTL and testbench

Parametrised serial sequence detector. It compares a runtime-loadable pattern of SEQ_LEN bits against a qualified serial bit stream, with overlapping or non-overlapping detection. It counts matches in a saturating counter and drives a 7-segment display with the low hex digit of that count, plus a detection flash on the decimal point. Successor to the fixed 3-bit detector; sits between the ui_in pins and the uo_out segment pins of a tile.

---
 rtl/seq_detect_param.sv | 115 +++++++++++
 tb/tb_seq_detect_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a runtime-loadable pattern,
// overlapping / non-overlapping detection, a saturating match counter and
// a 7-segment readout of the count's low hex digit (dp flashes on a match).
module seq_detect_param #(
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic [SEQ_LEN-1:0] pat_in,
    input  logic               pat_load,
    input  logic               overlap_en,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [7:0]         seg
);

    localparam int FW = $clog2(SEQ_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(SEQ_LEN);
    localparam logic [FW-1:0] NEED = FW'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Detection FSM states; the state is a pure function of fill.
    localparam logic [0:0] FILLING = 1'b0;
    localparam logic [0:0] ARMED   = 1'b1;

    logic [SEQ_LEN-1:0] pattern;
    logic [SEQ_LEN-1:0] history;
    logic [SEQ_LEN-1:0] nxt_hist;
    logic [FW-1:0]      fill;
    logic [0:0]         state;
    logic               accept;
    logic               hit;
    logic [6:0]         glyph;

    assign state    = (fill == FULL) ? ARMED : FILLING;
    // A load on the same edge wins, so the presented bit is dropped.
    assign accept   = ena & bit_valid & ~pat_load;
    assign nxt_hist = {history[SEQ_LEN-2:0], bit_in};
    // Hit needs SEQ_LEN held bits counting the incoming one.
    assign hit      = accept && (nxt_hist == pattern) &&
                      ((state == ARMED) || (fill == NEED));

    // Pattern capture, history shifting and fill tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= '0;
            history <= '0;
            fill    <= '0;
        end else if (ena) begin
            if (pat_load) begin
                pattern <= pat_in;
                history <= '0;
                fill    <= '0;
            end else if (bit_valid) begin
                history <= nxt_hist;
                // Non-overlapping: history still shifts but must be refilled.
                if (hit && !overlap_en)
                    fill <= '0;
                else if (fill != FULL)
                    fill <= fill + FW'(1);
            end
        end
    end

    // Registered one-cycle match pulse; held while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match <= 1'b0;
        else if (ena)
            match <= hit;
    end

    // Saturating match counter; clear beats a same-edge hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match_count <= '0;
        else if (ena) begin
            if (clr_cnt)
                match_count <= '0;
            else if (hit && (match_count != CNT_MAX))
                match_count <= match_count + CNT_W'(1);
        end
    end

    // Hex glyph of the count's low nibble, dp shows the match pulse.
    always_comb begin
        glyph = 7'h3F;
        case (match_count[3:0])
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h3F;
        endcase
        seg = {match, glyph};
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic; a
// queue-based reference model predicts every post-edge output and a
// separate monitor compares the DUT against it.
module tb_seq_detect_param;

    localparam int L = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic [L-1:0] pat_in = '0;
    logic         pat_load = 1'b0;
    logic         overlap_en = 1'b0;
    logic         clr_cnt = 1'b0;
    logic         match;
    logic [W-1:0] match_count;
    logic [7:0]   seg;

    seq_detect_param #(.SEQ_LEN(L), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bit_in(bit_in),
        .bit_valid(bit_valid), .pat_in(pat_in), .pat_load(pat_load),
        .overlap_en(overlap_en), .clr_cnt(clr_cnt), .match(match),
        .match_count(match_count), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [W-1:0] c;
        logic [7:0] s;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference model: the bits held since the last clear, oldest first
    bit         mq[$];
    logic [L-1:0] mpat = '0;
    logic       mm = 1'b0;
    int         mcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpat = '0;
        mm   = 1'b0;
        mcnt = 0;
    endtask

    task automatic model_edge();
        bit hit;
        exp_t e;
        hit = 1'b0;
        if (ena) begin
            if (pat_load) begin
                mpat = pat_in;
                mq.delete();
            end else if (bit_valid) begin
                mq.push_back(bit_in);
                if (mq.size() > L) void'(mq.pop_front());
                if (mq.size() == L) begin
                    hit = 1'b1;
                    for (int i = 0; i < L; i++)
                        if (mq[i] != mpat[L-1-i]) hit = 1'b0;
                end
                if (hit && !overlap_en) mq.delete();
            end
            mm = hit;
            if (clr_cnt) mcnt = 0;
            else if (hit && mcnt < (1 << W) - 1) mcnt++;
        end
        e.m = mm;
        e.c = W'(mcnt);
        e.s = {mm, GLYPH[mcnt % 16]};
        sbq.push_back(e);
    endtask

    // one clock: drive at the falling edge, predict at the rising edge
    task automatic cycle(input logic e, input logic v, input logic b,
                         input logic l, input logic c, input logic [L-1:0] p);
        ena = e; bit_valid = v; bit_in = b; pat_load = l; clr_cnt = c; pat_in = p;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send(input logic b);
        cycle(1'b1, 1'b1, b, 1'b0, 1'b0, '0);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic load(input logic [L-1:0] p);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, p);
    endtask

    task automatic clr();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    // monitor: compare DUT against the oldest prediction after each edge
    always @(posedge clk) begin
        #2;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if (match !== mon_e.m || match_count !== mon_e.c || seg !== mon_e.s) begin
                errors++;
                $display("FAIL edge@%0t: got match=%b count=%0d seg=%h expected match=%b count=%0d seg=%h",
                         $time, match, match_count, seg, mon_e.m, mon_e.c, mon_e.s);
            end
        end
    end

    logic [6:0] stream7 = 7'b1011011;

    initial begin
        // reset values while held
        #1;
        chk("reset_match", {31'd0, match}, 32'd0);
        chk("reset_count", {28'd0, match_count}, 32'd0);
        chk("reset_seg", {24'd0, seg}, 32'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // overlapping 1011 over 1,0,1,1,0,1,1
        overlap_en = 1'b1;
        load(4'b1011);
        for (int i = 6; i >= 0; i--) send(stream7[i]);
        idle();
        chk("ovl_count", {28'd0, match_count}, 32'd2);
        chk("ovl_seg", {24'd0, seg}, 32'h5B);

        // non-overlapping, same stream
        overlap_en = 1'b0;
        load(4'b1011); clr();
        for (int i = 6; i >= 0; i--) send(stream7[i]);
        idle();
        chk("novl_count", {28'd0, match_count}, 32'd1);

        // gaps of bit_valid=0 and ena=0 cause no shifts
        load(4'b1011); clr();
        for (int i = 3; i >= 0; i--) begin
            send(stream7[i+3]);
            if (i == 2) begin
                cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
                cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
            end
            if (i != 0) for (int g = 0; g < 3; g++) idle();
        end
        idle();
        chk("gap_count", {28'd0, match_count}, 32'd1);

        // pat_load drops a same-edge bit and clears history; count retained
        send(1'b1); send(1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011);
        send(1'b0); send(1'b1); send(1'b1);
        chk("load_nomatch_count", {28'd0, match_count}, 32'd1);
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        idle();
        chk("load_retain_count", {28'd0, match_count}, 32'd2);

        // saturation with 20 ones against 1111, then clear on a hit edge
        overlap_en = 1'b1;
        load(4'b1111); clr();
        for (int i = 0; i < 20; i++) send(1'b1);
        chk("sat_count", {28'd0, match_count}, 32'd15);
        chk("sat_glyph", {25'd0, seg[6:0]}, 32'h71);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0);
        chk("clr_hit_match", {31'd0, match}, 32'd1);
        chk("clr_hit_count", {28'd0, match_count}, 32'd0);

        // asynchronous reset mid-stream
        load(4'b1011); send(1'b1); send(1'b0); send(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_match", {31'd0, match}, 32'd0);
        chk("async_count", {28'd0, match_count}, 32'd0);
        chk("async_seg", {24'd0, seg}, 32'h3F);
        model_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);
        load(4'b1011);
        send(1'b1);
        idle();
        chk("post_reset_nomatch", {28'd0, match_count}, 32'd0);

        // random traffic
        load(4'b0110);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) overlap_en = $urandom_range(0, 1);
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 1),
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 39) == 0,
                  L'($urandom_range(0, (1 << L) - 1)));
        end
        idle();
        @(negedge clk);
        chk("queue_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
